// File: rtl/seq_alu.sv
// Clocked ALU with start/done handshake: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide producing hi/lo results.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    state_t             state_q;
    logic [SHW-1:0]     count_q;
    logic [2*WIDTH-1:0] acc_q;   // multiply: {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   opnd_q;  // multiplicand or divisor

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   op_result;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign shamt = A[SHW-1:0];

    always_comb begin
        op_result = '0;
        case (ALUControl)
            4'b0000: op_result = A + B;
            4'b0001: op_result = A - B;
            4'b0010: op_result = A & B;
            4'b0011: op_result = A | B;
            4'b0100: op_result = A ^ B;
            4'b0101: op_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b0110: op_result = {{(WIDTH-1){1'b0}}, (A < B)};
            4'b0111: op_result = ~(A | B);
            4'b1000: op_result = B << shamt;
            4'b1001: op_result = B >> shamt;
            4'b1010: op_result = $signed(B) >>> shamt;
            default: op_result = '0;
        endcase
    end

    // Carry out of the upper-half add becomes the new MSB as the accumulator shifts right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Remainder stays below the divisor, so the difference always fits in WIDTH bits.
    always_comb begin
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (ALUControl == OP_MULTU) begin
                            acc_q   <= {{WIDTH{1'b0}}, B};
                            opnd_q  <= A;
                            count_q <= '0;
                            busy    <= 1'b1;
                            state_q <= MUL;
                        end else if (ALUControl == OP_DIVU && B != '0) begin
                            quo_q   <= A;
                            rem_q   <= '0;
                            opnd_q  <= B;
                            count_q <= '0;
                            busy    <= 1'b1;
                            state_q <= DIV;
                        end else if (ALUControl == OP_DIVU) begin
                            lo        <= '1;
                            hi        <= A;
                            ALUResult <= '1;
                            Zero      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            ALUResult <= op_result;
                            Zero      <= (op_result == '0);
                            done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q   <= mul_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == SHW'(WIDTH-1)) begin
                        hi        <= mul_next[2*WIDTH-1:WIDTH];
                        lo        <= mul_next[WIDTH-1:0];
                        ALUResult <= mul_next[WIDTH-1:0];
                        Zero      <= (mul_next[WIDTH-1:0] == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DIV: begin
                    quo_q   <= quo_next;
                    rem_q   <= rem_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == SHW'(WIDTH-1)) begin
                        hi        <= rem_next;
                        lo        <= quo_next;
                        ALUResult <= quo_next;
                        Zero      <= (quo_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, hand-written multi-cycle
// sequences and randomized ops against a plain-arithmetic reference model.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, start8;
    logic [31:0] a, b, res, hi, lo;
    logic [3:0]  op, op8;
    logic        zero, busy, done;
    logic [7:0]  a8, b8, res8, hi8, lo8;
    logic        zero8, busy8, done8;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .ALUControl(op),
        .ALUResult(res), .Zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .ALUControl(op8),
        .ALUResult(res8), .Zero(zero8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit [63:0] m_hi = 0, m_lo = 0, m_res = 0;
    bit [63:0] m8_hi = 0, m8_lo = 0;

    typedef struct {
        bit [3:0]  op;
        bit [31:0] a;
        bit [31:0] b;
        bit [31:0] res;
        bit        z;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on w-bit values held in 64 bits.
    function automatic void model(input int w, input bit [3:0] o, input bit [63:0] x,
                                  input bit [63:0] y, inout bit [63:0] mhi,
                                  inout bit [63:0] mlo, output bit [63:0] r,
                                  output bit multi);
        bit [63:0] mask = (64'd1 << w) - 1;
        int        sh   = int'(x % 64'(w));
        longint    sx, sy;
        bit [63:0] p;
        sx = ((x >> (w - 1)) & 1) != 0 ? longint'(x) - longint'(mask) - 1 : longint'(x);
        sy = ((y >> (w - 1)) & 1) != 0 ? longint'(y) - longint'(mask) - 1 : longint'(y);
        multi = 1'b0;
        case (o)
            4'd0:  r = (x + y) & mask;
            4'd1:  r = (x - y) & mask;
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = (sx < sy) ? 1 : 0;
            4'd6:  r = (x < y) ? 1 : 0;
            4'd7:  r = ~(x | y) & mask;
            4'd8:  r = (y << sh) & mask;
            4'd9:  r = y >> sh;
            4'd10: begin
                r = y >> sh;
                if (((y >> (w - 1)) & 1) != 0) r = r | (mask & ~(mask >> sh));
            end
            4'd12: begin
                p = x * y;
                mhi = (p >> w) & mask;
                mlo = p & mask;
                r = mlo;
                multi = 1'b1;
            end
            4'd13: begin
                if (y == 0) begin
                    mlo = mask;
                    mhi = x;
                end else begin
                    mlo = x / y;
                    mhi = x % y;
                    multi = 1'b1;
                end
                r = mlo;
            end
            default: r = 0;
        endcase
    endfunction

    task automatic do_op(input bit [3:0] o, input bit [31:0] x, input bit [31:0] y,
                         input string name);
        bit [63:0] er;
        bit        mu;
        int        n;
        model(32, o, x, y, m_hi, m_lo, er, mu);
        m_res = er;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        if (mu) begin
            check({name, " busy"}, busy, 1);
            n = 0;
            while (!done && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check({name, " latency"}, n, 32);
            check({name, " busy end"}, busy, 0);
        end
        check({name, " done"}, done, 1);
        check({name, " res"}, res, er);
        check({name, " zero"}, zero, er == 0);
        check({name, " hi"}, hi, m_hi);
        check({name, " lo"}, lo, m_lo);
    endtask

    task automatic do_op8(input bit [3:0] o, input bit [7:0] x, input bit [7:0] y,
                          input string name);
        bit [63:0] er;
        bit        mu;
        int        n;
        model(8, o, x, y, m8_hi, m8_lo, er, mu);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, n, mu ? 8 : 0);
        check({name, " res"}, res8, er);
        check({name, " zero"}, zero8, er == 0);
        check({name, " hi"}, hi8, m8_hi);
        check({name, " lo"}, lo8, m8_lo);
    endtask

    initial begin
        bit [63:0] prev;
        int        busy_cnt, done_at, stray;
        bit        res_stable;
        bit [3:0]  o;
        bit [31:0] x, y;

        vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        vecs[1]  = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
        vecs[2]  = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        vecs[3]  = '{4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[4]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[5]  = '{4'b1010, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
        vecs[6]  = '{4'b1001, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0};
        vecs[7]  = '{4'b1000, 32'h00000008, 32'h000000FF, 32'h0000FF00, 1'b0};
        vecs[8]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[9]  = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
        vecs[10] = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
        vecs[11] = '{4'b1000, 32'h00000025, 32'h00000001, 32'h00000020, 1'b0};
        vecs[12] = '{4'b1011, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1};
        vecs[13] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[14] = '{4'b0101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[15] = '{4'b0110, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[16] = '{4'b1001, 32'h0000001F, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[17] = '{4'b1010, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset res", res, 0);
        check("reset zero", zero, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset8 res", res8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back single-cycle ops: done must stay high on every edge.
        foreach (vecs[i]) begin
            @(negedge clk);
            start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("vec%0d done", i), done, 1);
            check($sformatf("vec%0d res", i), res, vecs[i].res);
            check($sformatf("vec%0d zero", i), zero, vecs[i].z);
            check($sformatf("vec%0d hi", i), hi, 0);
            check($sformatf("vec%0d lo", i), lo, 0);
            m_res = vecs[i].res;
        end
        @(posedge clk); #1;
        check("idle done low", done, 0);

        // multu with add starts injected while busy and on the completion edge.
        prev = m_res;
        @(negedge clk);
        start = 1'b1; op = 4'b1100; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_at = -1;
        res_stable = 1'b1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            @(negedge clk);
            if (i % 4 == 0) begin
                start = 1'b1; op = 4'b0000; a = 32'd1; b = 32'd2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) done_at = i;
            else begin
                if (busy) busy_cnt++;
                if (res !== prev[31:0]) res_stable = 1'b0;
            end
        end
        check("multu max done edge", done_at, 32);
        check("multu max busy cycles", busy_cnt, 32);
        check("multu max res held", res_stable, 1);
        check("multu max hi", hi, 32'hFFFFFFFE);
        check("multu max lo", lo, 32'h00000001);
        check("multu max res", res, 32'h00000001);
        m_hi = 64'hFFFFFFFE; m_lo = 1; m_res = 1;
        @(posedge clk); #1;
        check("no queued start done", done, 0);
        check("no queued start busy", busy, 0);
        check("no queued start res", res, 32'h00000001);

        do_op(4'b1101, 32'd100, 32'd7, "divu 100/7");
        do_op(4'b1101, 32'h1234, 32'd0, "divu by zero");
        do_op(4'b0000, 32'd3, 32'd4, "add keeps hilo");

        // Asynchronous reset mid-multiply.
        @(negedge clk);
        start = 1'b1; op = 4'b1100; a = 32'd12345; b = 32'd6789;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort res", res, 0);
        check("abort zero", zero, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        m_hi = 0; m_lo = 0; m_res = 0; m8_hi = 0; m8_lo = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        check("no stray done after abort", stray, 0);
        do_op(4'b1100, 32'd3, 32'd5, "multu 3x5");

        // Randomized ops against the model; multi-cycle ops kept sparse.
        for (int i = 0; i < 150; i++) begin
            o = 4'($urandom_range(0, 15));
            if ((o == 4'd12 || o == 4'd13) && $urandom_range(0, 3) != 0) o = 4'd4;
            x = $urandom();
            y = $urandom();
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
            if (o == 4'd13 && $urandom_range(0, 4) == 0) y = 32'd0;
            do_op(o, x, y, $sformatf("rand%0d op%0d", i, o));
        end

        // WIDTH = 8 instance.
        do_op8(4'b1100, 8'hFF, 8'hFF, "w8 multu ff");
        do_op8(4'b1101, 8'd200, 8'd13, "w8 divu 200/13");
        do_op8(4'b1101, 8'h5A, 8'd0, "w8 divu by zero");
        do_op8(4'b1010, 8'd11, 8'h90, "w8 sra");
        for (int i = 0; i < 12; i++) begin
            o = ($urandom_range(0, 1) == 0) ? 4'd12 : 4'd13;
            do_op8(o, 8'($urandom()), 8'($urandom_range(1, 255)),
                   $sformatf("w8 rand%0d op%0d", i, o));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked ALU with a start/done handshake. It adds signed compare, XOR/NOR, shifts, and iterative unsigned multiply/divide (HI/LO results) to the add/sub/and/or/slt set of the single-cycle datapath ALU. It sits in the execute stage of the multi-cycle datapath. The control unit issues `start` with an opcode and waits for `done` before using `ALUResult`, `Zero`, `hi` or `lo`.

## Interface
- `WIDTH`, 32: operand/result width. Must be a power of two and ≥ 4.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request, sampled only in IDLE.
- `A`, `B`  in  WIDTH  operands.
- `ALUControl`  in  4  opcode.
- `ALUResult`  out  WIDTH  registered result.
- `Zero`  out  1  registered, (ALUResult == 0).
- `hi`, `lo`  out  WIDTH  multiply/divide result registers.
- `busy`  out  1  high while a multi-cycle op is in flight.
- `done`  out  1  one-cycle completion pulse.

Clock and reset are fixed: one clock; reset is asynchronous and active-low. All outputs are 0 during and after reset.

## Operation
Opcodes, with A and B captured at the start edge:
- 0000 add: A+B, wraps modulo 2^WIDTH.
- 0001 sub: A−B.
- 0010 and.
- 0011 or.
- 0100 xor.
- 0101 slt: signed A<B gives 1, else 0.
- 0110 sltu: unsigned compare.
- 0111 nor.
- 1000 sll: B << A[SHW-1:0].
- 1001 srl: logical right shift of B by the same amount.
- 1010 sra: arithmetic right shift of B by the same amount.
- 1100 multu: {hi,lo} = A*B, unsigned, 2·WIDTH bits. ALUResult = lo.
- 1101 divu: lo = A/B, hi = A%B, unsigned. ALUResult = lo.
- Any other opcode: single-cycle, ALUResult = 0, Zero = 1.

FSM states are IDLE, MUL and DIV.
- IDLE + start + single-cycle opcode: ALUResult, Zero and done=1 are written at that edge. State stays IDLE.
- IDLE + start + multu:
  - Load the multiplicand, the multiplier and a 2·WIDTH-bit accumulator = 0.
  - Set count = 0 and busy = 1, go to MUL.
  - Shift-add one multiplier bit per edge.
- IDLE + start + divu with B ≠ 0:
  - Load the dividend into a shift register and a (WIDTH+1)-bit remainder = 0.
  - Set count = 0 and busy = 1, go to DIV.
  - Restoring division, one quotient bit per edge.
- IDLE + start + divu with B = 0: completes in a single cycle. lo = all ones, hi = A, ALUResult = all ones, Zero = 0.
- MUL/DIV: count increments on every edge. The edge with count == WIDTH−1 performs the final iteration and writes hi, lo, ALUResult and Zero, sets done = 1 and busy = 0, and returns to IDLE.
- `start` is ignored outside IDLE, including the completion edge. No queuing.
- hi and lo change only on multu/divu completion. Single-cycle ops leave them untouched.
- ALUResult and Zero hold until the next completion.
- `rst_n` low at any time, including mid-MUL/DIV:
  - The operation aborts immediately.
  - State goes to IDLE.
  - Every output and internal register clears to 0.
  - No done pulse is generated for the aborted op.

## Timing
- Start accepted at edge k.
- Single-cycle op (including divu by zero): results and done visible after edge k. Latency is 1.
- multu/divu: busy is high after edges k … k+WIDTH−1. Results and done are visible after edge k+WIDTH. Latency is WIDTH+1, i.e. 33 cycles at WIDTH=32.
- done is high for exactly one cycle per accepted start.
- Back-to-back single-cycle ops can be accepted on every edge, giving done high continuously.
- Next multi-cycle start is accepted at edge k+WIDTH+1 at the earliest.
- Operands need to be valid only at the start edge.

## Test plan
- add 0x7FFFFFFF + 0x00000001: expect ALUResult = 0x80000000, Zero = 0, done one cycle after the start edge. Then sub 5 − 5: expect 0, Zero = 1 on the next cycle (back-to-back issue).
- A = 0xFFFFFFFF, B = 1:
  - slt → 1.
  - sltu → 0.
  - nor → 0x00000000 with Zero = 1.
  - sra B = 0x80000000, A = 4 → 0xF8000000.
  - srl of the same operands → 0x08000000.
- multu 0xFFFFFFFF × 0xFFFFFFFF:
  - Expect hi = 0xFFFFFFFE, lo = 0x00000001.
  - busy high 32 cycles, done exactly 32 edges after the start edge.
  - Start pulses with opcode add during busy are ignored: no extra done, ALUResult unchanged until completion.
- divu 100 / 7: expect lo = 14, hi = 2, latency 33. Then divu 0x1234 / 0: expect lo = 0xFFFFFFFF, hi = 0x1234, done after 1 cycle.
- Assert rst_n low 10 cycles into a multu: all outputs read 0 immediately, without waiting for a clock. Release reset, issue multu 3 × 5: expect lo = 15, hi = 0, with no stray done from the aborted op.
- Re-run multu/divu with WIDTH = 8: 0xFF × 0xFF gives hi = 0xFE, lo = 0x01 after 9-cycle latency.
